lab3_input_ctrl: RTL and testbench

Input-conditioning stage that sits directly upstream of the lab3 LED pattern FSM. It turns the two raw push buttons into clean `en` and `dir` levels, and produces a one-cycle `tick` strobe. It performs 2-flop synchronisation, counter-based debounce, rising-edge one-pulse and toggle-on-press per button. The FSM consumes `en`/`dir` as levels and uses `tick` as its step enable, which replaces a divided clock.

---
 rtl/lab3_input_ctrl_if.sv | 23 ++
 rtl/lab3_input_ctrl.sv | 94 +++++++++
 tb/tb_lab3_input_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_input_ctrl_if.sv
// Button/level/strobe bundle between the raw push buttons, the input-conditioning
// stage and the downstream LED pattern FSM.
interface lab3_input_ctrl_if;
  logic btn_en;
  logic btn_dir;
  logic en;
  logic dir;
  logic en_pulse;
  logic dir_pulse;
  logic tick;

  // Driver side: raw buttons in, conditioned levels and strobes back.
  modport master (
    output btn_en, btn_dir,
    input  en, dir, en_pulse, dir_pulse, tick
  );

  // Conditioning stage side.
  modport slave (
    input  btn_en, btn_dir,
    output en, dir, en_pulse, dir_pulse, tick
  );
endinterface

// File: rtl/lab3_input_ctrl.sv
// Two-button input conditioner: sync, debounce, press one-pulse and toggle level,
// plus a power-of-two tick strobe. Define LAB3_TICK_GATE_EN to freeze the tick while en=0.
module lab3_input_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18,
  parameter int TICK_DIV  = 25
) (
  input logic             clk,
  input logic             rst,
  lab3_input_ctrl_if.slave io
);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_DIV-1:0] TCNT_LAST = '1;

  logic [1:0] btn_raw;
  logic [1:0] pulse;
  logic [1:0] level;

  // Channel 0 is the enable button, channel 1 the direction button.
  assign btn_raw = {io.btn_dir, io.btn_en};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic            s1_reg;
      logic            s2_reg;
      logic            db_reg;
      logic [DB_W-1:0] cnt_reg;
      logic            pulse_reg;
      logic            level_reg;
      logic            rise;

      // A completed count toward 1 is the press event; release is silent.
      assign rise = s2_reg && !db_reg && (cnt_reg == DB_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
          level_reg <= 1'b0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            db_reg  <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          pulse_reg <= rise;
          level_reg <= level_reg ^ rise;
        end
      end

      assign pulse[gi] = pulse_reg;
      assign level[gi] = level_reg;
    end
  endgenerate

  logic [TICK_DIV-1:0] tcnt_reg;
  logic                tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
`ifdef LAB3_TICK_GATE_EN
      // Paused pattern: hold the phase so stepping resumes where it left off.
      if (level[0]) begin
        tcnt_reg <= tcnt_reg + 1'b1;
        tick_reg <= (tcnt_reg == TCNT_LAST);
      end else begin
        tick_reg <= 1'b0;
      end
`else
      tcnt_reg <= tcnt_reg + 1'b1;
      tick_reg <= (tcnt_reg == TCNT_LAST);
`endif
    end
  end

  assign io.en        = level[0];
  assign io.dir       = level[1];
  assign io.en_pulse  = pulse[0];
  assign io.dir_pulse = pulse[1];
  assign io.tick      = tick_reg;

endmodule

// File: tb/tb_lab3_input_ctrl.sv
// Self-checking bench for lab3_input_ctrl: directed phases plus random button traffic
// compared against a sliding-window behavioural model.
module tb_lab3_input_ctrl;

  localparam int DB_CYCLES   = 4;
  localparam int DB_W        = 3;
  localparam int TICK_DIV    = 3;
  localparam int TICK_PERIOD = 1 << TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lab3_input_ctrl_if bus ();

  lab3_input_ctrl #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two-sample input delay, then a window of consecutive
  // samples that disagree with the stored level; a full window commits the change.
  bit pipe_q [2][$];
  bit win_q  [2][$];
  bit m_db    [2];
  bit m_lvl   [2];
  bit m_pulse [2];
  bit m_tick;
  int m_tcount;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      pipe_q[ch].delete();
      pipe_q[ch].push_back(1'b0);
      pipe_q[ch].push_back(1'b0);
      win_q[ch].delete();
      m_db[ch]    = 1'b0;
      m_lvl[ch]   = 1'b0;
      m_pulse[ch] = 1'b0;
    end
    m_tick   = 1'b0;
    m_tcount = 0;
  endtask

  task automatic model_edge(input bit r, input bit be, input bit bd);
    bit raw [2];
    bit s;
    bit en_before;
    raw[0] = be;
    raw[1] = bd;
    if (r) begin
      model_reset();
      return;
    end
    en_before = m_lvl[0];
    for (int ch = 0; ch < 2; ch++) begin
      s = pipe_q[ch][0];
      m_pulse[ch] = 1'b0;
      if (s == m_db[ch]) win_q[ch].delete();
      else win_q[ch].push_back(s);
      if (win_q[ch].size() == DB_CYCLES) begin
        m_db[ch] = s;
        win_q[ch].delete();
        if (s) begin
          m_pulse[ch] = 1'b1;
          m_lvl[ch]   = ~m_lvl[ch];
        end
      end
      pipe_q[ch].push_back(raw[ch]);
      void'(pipe_q[ch].pop_front());
    end
`ifdef LAB3_TICK_GATE_EN
    if (en_before) begin
      m_tcount++;
      m_tick = (m_tcount % TICK_PERIOD) == 0;
    end else begin
      m_tick = 1'b0;
    end
`else
    m_tcount++;
    m_tick = (m_tcount % TICK_PERIOD) == 0;
`endif
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, clock, advance model, compare all outputs 1 time unit later.
  task automatic step(input string phase, input bit r, input bit be, input bit bd);
    rst        = r;
    bus.btn_en  = be;
    bus.btn_dir = bd;
    @(posedge clk);
    model_edge(r, be, bd);
    #1;
    check_bit({phase, ".en"},        bus.en,        m_lvl[0]);
    check_bit({phase, ".dir"},       bus.dir,       m_lvl[1]);
    check_bit({phase, ".en_pulse"},  bus.en_pulse,  m_pulse[0]);
    check_bit({phase, ".dir_pulse"}, bus.dir_pulse, m_pulse[1]);
    check_bit({phase, ".tick"},      bus.tick,      m_tick);
  endtask

  initial begin
    int first_tick;
    int first_en;
    int first_dir;
    int pulses;
    int ticks;
    bit be;
    bit bd;
    int hold;
    bit bounce [8];

    model_reset();
    bus.btn_en  = 1'b0;
    bus.btn_dir = 1'b0;

    // 1. Reset with random buttons, then first tick after the 8th edge.
    for (int i = 0; i < 3; i++)
      step("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    first_tick = -1;
    for (int i = 0; i < 20; i++) begin
      step("tick0", 1'b0, 1'b0, 1'b0);
      if (bus.tick && first_tick < 0) first_tick = i + 1;
    end
    check_int("first_tick_edge", first_tick, TICK_PERIOD);

    // 2. Clean press, release, second press.
    first_en = -1;
    pulses   = 0;
    for (int i = 0; i < 20; i++) begin
      step("press1", 1'b0, 1'b1, 1'b0);
      if (bus.en_pulse) begin
        pulses++;
        if (first_en < 0) first_en = i;
      end
    end
    check_int("press1_pulse_edge", first_en, DB_CYCLES + 1);
    check_int("press1_pulse_count", pulses, 1);
    for (int i = 0; i < 20; i++) step("release1", 1'b0, 1'b0, 1'b0);
    check_bit("release1_en_held", bus.en, 1'b1);
    for (int i = 0; i < 20; i++) step("press2", 1'b0, 1'b1, 1'b0);
    check_bit("press2_en_toggled", bus.en, 1'b0);
    for (int i = 0; i < 10; i++) step("release2", 1'b0, 1'b0, 1'b0);

    // 3. Bouncing button never reaches a full stable window.
    bounce = '{1, 1, 1, 0, 1, 1, 1, 0};
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step("bounce", 1'b0, bounce[i % 8], 1'b0);
      if (bus.en_pulse) pulses++;
    end
    check_int("bounce_pulse_count", pulses, 0);
    for (int i = 0; i < 10; i++) step("idle3", 1'b0, 1'b0, 1'b0);

    // 4. Simultaneous presses.
    first_en  = -1;
    first_dir = -1;
    for (int i = 0; i < 15; i++) begin
      step("simul", 1'b0, 1'b1, 1'b1);
      if (bus.en_pulse && first_en < 0) first_en = i;
      if (bus.dir_pulse && first_dir < 0) first_dir = i;
    end
    check_int("simul_en_edge", first_en, DB_CYCLES + 1);
    check_int("simul_dir_edge", first_dir, DB_CYCLES + 1);
    for (int i = 0; i < 10; i++) step("idle4", 1'b0, 1'b0, 1'b0);

    // 5. Reset mid-debounce on the direction button.
    for (int i = 0; i < 3; i++) step("middb", 1'b0, 1'b0, 1'b1);
    step("middb_rst", 1'b1, 1'b0, 1'b1);
    first_dir = -1;
    for (int i = 0; i < 12; i++) begin
      step("middb_post", 1'b0, 1'b0, 1'b1);
      if (bus.dir_pulse && first_dir < 0) first_dir = i;
    end
    check_int("middb_dir_edge", first_dir, DB_CYCLES + 1);
    for (int i = 0; i < 10; i++) step("idle5", 1'b0, 1'b0, 1'b0);

    // 6. en=0 idle window (tick frozen when gated), then press to resume.
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step("en_low", 1'b0, 1'b0, 1'b0);
      if (bus.tick) ticks++;
    end
`ifdef LAB3_TICK_GATE_EN
    check_int("gated_tick_count", ticks, 0);
`endif
    for (int i = 0; i < 20; i++) step("en_press", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step("en_run", 1'b0, 1'b0, 1'b0);

    // 7. Random button traffic with occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      be   = 1'($urandom_range(0, 1));
      bd   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++)
        step("random", ($urandom_range(0, 49) == 0), be, bd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
